// File: rtl/ctl_reg_reader.sv
// ctl_reg_reader: copies the modulation (MOD) and STM setting groups out of the
// controller BRAM into shadow registers. It watches the control flag word for
// rising set bits, reads the matching group, and then presents the whole group
// at once with a one-cycle update pulse.
// Build option: define CTL_REG_READER_STM_EN to include the STM group. When it
// is undefined, the STM set bit is ignored and every stm_* output stays 0.
//
// state    | meaning
// PRIME    | hold bram_addr at the flag word for 2 cycles so read data is valid
// IDLE     | poll the flag word and look for rising MOD_SET / STM_SET bits
// MOD_RD   | issue addresses 0x22..0x2D and capture the returned words
// MOD_DONE | mod_* outputs updated this cycle, mod_update high
// STM_RD   | issue addresses 0x52..0x63 and capture the returned words
// STM_DONE | stm_* outputs updated this cycle, stm_update high
module ctl_reg_reader #(
  parameter int STM_WORDS = 18
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  bram_addr,
  input  logic [15:0] bram_dout,
  output logic        mod_req_rd_segment,
  output logic [31:0] mod_cycle,
  output logic [31:0] mod_freq_div,
  output logic [31:0] mod_rep,
  output logic [7:0]  mod_transition_mode,
  output logic [63:0] mod_transition_value,
  output logic        mod_update,
  output logic        stm_req_rd_segment,
  output logic [31:0] stm_cycle,
  output logic [31:0] stm_freq_div,
  output logic [31:0] stm_rep,
  output logic        stm_mode,
  output logic [31:0] stm_sound_speed,
  output logic [7:0]  stm_num_foci,
  output logic [7:0]  stm_transition_mode,
  output logic [63:0] stm_transition_value,
  output logic        stm_update,
  output logic        busy
);

  localparam int MOD_WORDS = 12;
  localparam int CNT_MAX   = ((STM_WORDS > MOD_WORDS) ? STM_WORDS : MOD_WORDS) + 1;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [7:0] ADDR_CTL_FLAG = 8'h00;
  localparam logic [7:0] MOD_BASE      = 8'h22;
  localparam logic [7:0] MOD_LAST      = 8'h2D;

  typedef enum logic [2:0] {
    PRIME    = 3'd0,
    IDLE     = 3'd1,
    MOD_RD   = 3'd2,
    MOD_DONE = 3'd3
`ifdef CTL_REG_READER_STM_EN
    ,
    STM_RD   = 3'd4,
    STM_DONE = 3'd5
`endif
  } state_t;

  state_t           state;
  logic             prime_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [7:0]       addr_d1;
  logic [7:0]       addr_d2;
  logic             prev_mod;

  logic             sh_mod_seg;
  logic [31:0]      sh_mod_cycle;
  logic [31:0]      sh_mod_freq;
  logic [31:0]      sh_mod_rep;
  logic [7:0]       sh_mod_tmode;
  logic [47:0]      sh_mod_tval;

`ifdef CTL_REG_READER_STM_EN
  localparam logic [7:0] STM_BASE = 8'h52;
  localparam logic [7:0] STM_LAST = 8'(32'(STM_BASE) + STM_WORDS - 1);

  logic             prev_stm;
  logic             sh_stm_seg;
  logic [31:0]      sh_stm_cycle;
  logic [31:0]      sh_stm_freq;
  logic [31:0]      sh_stm_rep;
  logic             sh_stm_mode;
  logic [31:0]      sh_stm_sound;
  logic [7:0]       sh_stm_foci;
  logic [7:0]       sh_stm_tmode;
  logic [47:0]      sh_stm_tval;
`else
  assign stm_req_rd_segment   = 1'b0;
  assign stm_cycle            = '0;
  assign stm_freq_div         = '0;
  assign stm_rep              = '0;
  assign stm_mode             = 1'b0;
  assign stm_sound_speed      = '0;
  assign stm_num_foci         = '0;
  assign stm_transition_mode  = '0;
  assign stm_transition_value = '0;
  assign stm_update           = 1'b0;
`endif

  // Step through a group's addresses; park on the flag word once past the last one.
  function automatic logic [7:0] next_addr(input logic [7:0] a, input logic [7:0] last);
    return (a == last || a == ADDR_CTL_FLAG) ? ADDR_CTL_FLAG : a + 8'h01;
  endfunction

  assign busy = (state != IDLE);

  // Sequencer, read-address pipeline, shadow capture and atomic output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= PRIME;
      prime_cnt            <= 1'b1;
      rd_cnt               <= '0;
      bram_addr            <= ADDR_CTL_FLAG;
      addr_d1              <= '0;
      addr_d2              <= '0;
      prev_mod             <= 1'b0;
      sh_mod_seg           <= 1'b0;
      sh_mod_cycle         <= '0;
      sh_mod_freq          <= '0;
      sh_mod_rep           <= '0;
      sh_mod_tmode         <= '0;
      sh_mod_tval          <= '0;
      mod_req_rd_segment   <= 1'b0;
      mod_cycle            <= '0;
      mod_freq_div         <= '0;
      mod_rep              <= '0;
      mod_transition_mode  <= '0;
      mod_transition_value <= '0;
      mod_update           <= 1'b0;
`ifdef CTL_REG_READER_STM_EN
      prev_stm             <= 1'b0;
      sh_stm_seg           <= 1'b0;
      sh_stm_cycle         <= '0;
      sh_stm_freq          <= '0;
      sh_stm_rep           <= '0;
      sh_stm_mode          <= 1'b0;
      sh_stm_sound         <= '0;
      sh_stm_foci          <= '0;
      sh_stm_tmode         <= '0;
      sh_stm_tval          <= '0;
      stm_req_rd_segment   <= 1'b0;
      stm_cycle            <= '0;
      stm_freq_div         <= '0;
      stm_rep              <= '0;
      stm_mode             <= 1'b0;
      stm_sound_speed      <= '0;
      stm_num_foci         <= '0;
      stm_transition_mode  <= '0;
      stm_transition_value <= '0;
      stm_update           <= 1'b0;
`endif
    end else begin
      // addr_d2 names the word that bram_dout carries this cycle
      addr_d1    <= bram_addr;
      addr_d2    <= addr_d1;
      mod_update <= 1'b0;
`ifdef CTL_REG_READER_STM_EN
      stm_update <= 1'b0;
`endif
      case (state)
        PRIME: begin
          bram_addr <= ADDR_CTL_FLAG;
          if (prime_cnt) prime_cnt <= 1'b0;
          else           state     <= IDLE;
        end

        IDLE: begin
          bram_addr <= ADDR_CTL_FLAG;
          prev_mod  <= bram_dout[0];
          if (bram_dout[0] && !prev_mod) begin
            state     <= MOD_RD;
            bram_addr <= MOD_BASE;
            rd_cnt    <= CNT_W'(MOD_WORDS + 1);
`ifdef CTL_REG_READER_STM_EN
            // a simultaneous STM rise stays pending for the next IDLE pass
            prev_stm  <= prev_stm & bram_dout[1];
          end else if (bram_dout[1] && !prev_stm) begin
            state     <= STM_RD;
            bram_addr <= STM_BASE;
            rd_cnt    <= CNT_W'(STM_WORDS + 1);
            prev_stm  <= 1'b1;
          end else begin
            prev_stm  <= bram_dout[1];
`endif
          end
        end

        MOD_RD: begin
          bram_addr <= next_addr(bram_addr, MOD_LAST);
          case (addr_d2)
            8'h22: sh_mod_seg          <= bram_dout[0];
            8'h23: sh_mod_cycle[15:0]  <= bram_dout;
            8'h24: sh_mod_cycle[31:16] <= bram_dout;
            8'h25: sh_mod_freq[15:0]   <= bram_dout;
            8'h26: sh_mod_freq[31:16]  <= bram_dout;
            8'h27: sh_mod_rep[15:0]    <= bram_dout;
            8'h28: sh_mod_rep[31:16]   <= bram_dout;
            8'h29: sh_mod_tmode        <= bram_dout[7:0];
            8'h2A: sh_mod_tval[15:0]   <= bram_dout;
            8'h2B: sh_mod_tval[31:16]  <= bram_dout;
            8'h2C: sh_mod_tval[47:32]  <= bram_dout;
            default: ;
          endcase
          if (rd_cnt == '0) begin
            // last word (0x2D) is merged straight in so the group lands in one edge
            state                <= MOD_DONE;
            mod_req_rd_segment   <= sh_mod_seg;
            mod_cycle            <= sh_mod_cycle;
            mod_freq_div         <= sh_mod_freq;
            mod_rep              <= sh_mod_rep;
            mod_transition_mode  <= sh_mod_tmode;
            mod_transition_value <= {bram_dout, sh_mod_tval};
            mod_update           <= 1'b1;
          end else begin
            rd_cnt <= rd_cnt - CNT_W'(1);
          end
        end

        MOD_DONE: begin
          state     <= PRIME;
          prime_cnt <= 1'b1;
          bram_addr <= ADDR_CTL_FLAG;
        end

`ifdef CTL_REG_READER_STM_EN
        STM_RD: begin
          bram_addr <= next_addr(bram_addr, STM_LAST);
          case (addr_d2)
            8'h52: sh_stm_seg          <= bram_dout[0];
            8'h53: sh_stm_cycle[15:0]  <= bram_dout;
            8'h54: sh_stm_cycle[31:16] <= bram_dout;
            8'h55: sh_stm_freq[15:0]   <= bram_dout;
            8'h56: sh_stm_freq[31:16]  <= bram_dout;
            8'h57: sh_stm_rep[15:0]    <= bram_dout;
            8'h58: sh_stm_rep[31:16]   <= bram_dout;
            8'h59: sh_stm_mode         <= bram_dout[0];
            8'h5B: sh_stm_sound[15:0]  <= bram_dout;
            8'h5C: sh_stm_sound[31:16] <= bram_dout;
            8'h5D: sh_stm_foci         <= bram_dout[7:0];
            8'h5F: sh_stm_tmode        <= bram_dout[7:0];
            8'h60: sh_stm_tval[15:0]   <= bram_dout;
            8'h61: sh_stm_tval[31:16]  <= bram_dout;
            8'h62: sh_stm_tval[47:32]  <= bram_dout;
            default: ;  // 0x5A and 0x5E are read but carry nothing
          endcase
          if (rd_cnt == '0) begin
            state                <= STM_DONE;
            stm_req_rd_segment   <= sh_stm_seg;
            stm_cycle            <= sh_stm_cycle;
            stm_freq_div         <= sh_stm_freq;
            stm_rep              <= sh_stm_rep;
            stm_mode             <= sh_stm_mode;
            stm_sound_speed      <= sh_stm_sound;
            stm_num_foci         <= sh_stm_foci;
            stm_transition_mode  <= sh_stm_tmode;
            stm_transition_value <= {bram_dout, sh_stm_tval};
            stm_update           <= 1'b1;
          end else begin
            rd_cnt <= rd_cnt - CNT_W'(1);
          end
        end

        STM_DONE: begin
          state     <= PRIME;
          prime_cnt <= 1'b1;
          bram_addr <= ADDR_CTL_FLAG;
        end
`endif

        default: begin
          state     <= PRIME;
          prime_cnt <= 1'b1;
          bram_addr <= ADDR_CTL_FLAG;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctl_reg_reader.sv
// Testbench for ctl_reg_reader: a 2-cycle-latency BRAM model feeds the reader;
// each expected update is queued with the cycle it must appear in and the
// monitor checks every update pulse against the head of that queue.
module tb_ctl_reg_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  bram_addr;
  logic [15:0] bram_dout = '0;
  logic        mod_req_rd_segment, mod_update;
  logic [31:0] mod_cycle, mod_freq_div, mod_rep;
  logic [7:0]  mod_transition_mode;
  logic [63:0] mod_transition_value;
  logic        stm_req_rd_segment, stm_mode, stm_update;
  logic [31:0] stm_cycle, stm_freq_div, stm_rep, stm_sound_speed;
  logic [7:0]  stm_num_foci, stm_transition_mode;
  logic [63:0] stm_transition_value;
  logic        busy;

  ctl_reg_reader dut (
    .clk(clk), .rst(rst), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .mod_req_rd_segment(mod_req_rd_segment), .mod_cycle(mod_cycle),
    .mod_freq_div(mod_freq_div), .mod_rep(mod_rep),
    .mod_transition_mode(mod_transition_mode),
    .mod_transition_value(mod_transition_value), .mod_update(mod_update),
    .stm_req_rd_segment(stm_req_rd_segment), .stm_cycle(stm_cycle),
    .stm_freq_div(stm_freq_div), .stm_rep(stm_rep), .stm_mode(stm_mode),
    .stm_sound_speed(stm_sound_speed), .stm_num_foci(stm_num_foci),
    .stm_transition_mode(stm_transition_mode),
    .stm_transition_value(stm_transition_value), .stm_update(stm_update),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:255];
  logic [15:0] bram_d1 = '0;
  always @(posedge clk) begin
    bram_d1   <= mem[bram_addr];
    bram_dout <= bram_d1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          stm;
    int          cyc;
    logic        seg;
    logic [31:0] cycle, freq, rep, sound;
    logic        mode;
    logic [7:0]  foci, tmode;
    logic [63:0] tval;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_mod(input int at, input logic seg, input logic [31:0] c, input logic [31:0] f,
                          input logic [31:0] r, input logic [7:0] tm, input logic [63:0] tv);
    exp_t e;
    e.stm = 1'b0; e.cyc = at; e.seg = seg; e.cycle = c; e.freq = f; e.rep = r;
    e.tmode = tm; e.tval = tv; e.mode = 1'b0; e.sound = '0; e.foci = '0;
    q.push_back(e);
  endtask

`ifdef CTL_REG_READER_STM_EN
  task automatic push_stm(input int at);
    exp_t e;
    e.stm = 1'b1; e.cyc = at; e.seg = 1'b1; e.cycle = 32'h0001_5678; e.freq = 32'd2;
    e.rep = 32'd7; e.mode = 1'b1; e.sound = 32'h0005_0154; e.foci = 8'd8;
    e.tmode = 8'h02; e.tval = 64'hDDDD_CCCC_BBBB_AAAA;
    q.push_back(e);
  endtask
`endif

  // Monitor: every update pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (mod_update) begin
      if (q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL mod_update_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        chk("mod_kind", 64'(e.stm), 64'(0));
        chk("mod_time", 64'(cyc), 64'(e.cyc));
        chk("mod_seg", 64'(mod_req_rd_segment), 64'(e.seg));
        chk("mod_cycle", 64'(mod_cycle), 64'(e.cycle));
        chk("mod_freq_div", 64'(mod_freq_div), 64'(e.freq));
        chk("mod_rep", 64'(mod_rep), 64'(e.rep));
        chk("mod_tmode", 64'(mod_transition_mode), 64'(e.tmode));
        chk("mod_tval", mod_transition_value, e.tval);
      end
    end
    if (stm_update) begin
      if (q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL stm_update_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        chk("stm_kind", 64'(e.stm), 64'(1));
        chk("stm_time", 64'(cyc), 64'(e.cyc));
        chk("stm_seg", 64'(stm_req_rd_segment), 64'(e.seg));
        chk("stm_cycle", 64'(stm_cycle), 64'(e.cycle));
        chk("stm_freq_div", 64'(stm_freq_div), 64'(e.freq));
        chk("stm_rep", 64'(stm_rep), 64'(e.rep));
        chk("stm_mode", 64'(stm_mode), 64'(e.mode));
        chk("stm_sound", 64'(stm_sound_speed), 64'(e.sound));
        chk("stm_foci", 64'(stm_num_foci), 64'(e.foci));
        chk("stm_tmode", 64'(stm_transition_mode), 64'(e.tmode));
        chk("stm_tval", stm_transition_value, e.tval);
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_addr", 64'(bram_addr), 64'h00);
    chk("rst_mod_update", 64'(mod_update), 64'(0));
    chk("rst_mod_cycle", 64'(mod_cycle), 64'(0));
    chk("rst_stm_cycle", 64'(stm_cycle), 64'(0));

    // release with flag word 0: two PRIME cycles then idle, nothing read
    rst = 1'b0;
    @(negedge clk);
    chk("prime_busy", 64'(busy), 64'(1));
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_addr", 64'(bram_addr), 64'h00);
    repeat (48) @(negedge clk);
    chk("idle50_busy", 64'(busy), 64'(0));
    chk("idle50_addr", 64'(bram_addr), 64'h00);

    // modulation group read
    mem[8'h22] = 16'h0003; mem[8'h23] = 16'h1234; mem[8'h24] = 16'h0000;
    mem[8'h25] = 16'h0005; mem[8'h26] = 16'h0000; mem[8'h27] = 16'h0003;
    mem[8'h28] = 16'h8000; mem[8'h29] = 16'hFF01; mem[8'h2A] = 16'h1111;
    mem[8'h2B] = 16'h2222; mem[8'h2C] = 16'h3333; mem[8'h2D] = 16'h4444;
    @(negedge clk);
    n = cyc;
    mem[8'h00] = 16'h0001;
    push_mod(n + 17, 1'b1, 32'h0000_1234, 32'd5, 32'h8000_0003, 8'h01, 64'h4444_3333_2222_1111);
    repeat (16) @(negedge clk);
    chk("mod_hold_before_update", 64'(mod_cycle), 64'(0));
    chk("mod_busy_reading", 64'(busy), 64'(1));
    repeat (5) @(negedge clk);
    chk("mod_cycle_held", 64'(mod_cycle), 64'h1234);
    chk("mod_busy_after", 64'(busy), 64'(0));

    // flag held high: no retrigger; then drop and raise again with new data
    repeat (200) @(negedge clk);
    mem[8'h00] = 16'h0000;
    repeat (5) @(negedge clk);
    mem[8'h23] = 16'hABCD; mem[8'h2B] = 16'h5555;
    @(negedge clk);
    n = cyc;
    mem[8'h00] = 16'h0001;
    push_mod(n + 17, 1'b1, 32'h0000_ABCD, 32'd5, 32'h8000_0003, 8'h01, 64'h4444_3333_5555_1111);
    repeat (25) @(negedge clk);

    // reset six cycles after detect aborts the read; flag still high at release retriggers
    mem[8'h00] = 16'h0000;
    repeat (5) @(negedge clk);
    mem[8'h25] = 16'h0009;
    @(negedge clk);
    mem[8'h00] = 16'h0001;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_mod_cycle", 64'(mod_cycle), 64'(0));
    chk("abort_mod_freq", 64'(mod_freq_div), 64'(0));
    chk("abort_busy_prime", 64'(busy), 64'(1));
    chk("abort_addr", 64'(bram_addr), 64'h00);
    rst = 1'b0;
    n = cyc;
    push_mod(n + 17, 1'b1, 32'h0000_ABCD, 32'd9, 32'h8000_0003, 8'h01, 64'h4444_3333_5555_1111);
    repeat (25) @(negedge clk);

    // STM group contents
    mem[8'h00] = 16'h0000;
    mem[8'h52] = 16'h0001; mem[8'h53] = 16'h5678; mem[8'h54] = 16'h0001;
    mem[8'h55] = 16'h0002; mem[8'h56] = 16'h0000; mem[8'h57] = 16'h0007;
    mem[8'h58] = 16'h0000; mem[8'h59] = 16'h0003; mem[8'h5A] = 16'hDEAD;
    mem[8'h5B] = 16'h0154; mem[8'h5C] = 16'h0005; mem[8'h5D] = 16'h0008;
    mem[8'h5E] = 16'hBEEF; mem[8'h5F] = 16'h0002; mem[8'h60] = 16'hAAAA;
    mem[8'h61] = 16'hBBBB; mem[8'h62] = 16'hCCCC; mem[8'h63] = 16'hDDDD;
    repeat (5) @(negedge clk);
`ifdef CTL_REG_READER_STM_EN
    // both set bits rise together: MOD first, STM on the next idle pass
    @(negedge clk);
    n = cyc;
    mem[8'h00] = 16'h0003;
    push_mod(n + 17, 1'b1, 32'h0000_ABCD, 32'd9, 32'h8000_0003, 8'h01, 64'h4444_3333_5555_1111);
    push_stm(n + 41);
    repeat (60) @(negedge clk);
    chk("stm_foci_held", 64'(stm_num_foci), 64'd8);
    chk("stm_busy_after", 64'(busy), 64'(0));
`else
    // STM group compiled out: its set bit must be ignored
    @(negedge clk);
    mem[8'h00] = 16'h0002;
    repeat (60) @(negedge clk);
    chk("nostm_cycle", 64'(stm_cycle), 64'(0));
    chk("nostm_foci", 64'(stm_num_foci), 64'(0));
    chk("nostm_seg", 64'(stm_req_rd_segment), 64'(0));
    chk("nostm_busy", 64'(busy), 64'(0));
`endif

    chk("pending_updates", 64'(q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctl_reg_reader.md
CTL_REG_READER -- requirements
Module: ctl_reg_reader

Interface
REQ-001 Parameter STM_WORDS, default 18, number of STM-group words read per STM update (fixed, not user-tuned).
REQ-002 CLK  in  1  system clock; single clock domain.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 BRAM_ADDR  out  8  controller-BRAM read address (bram_addr_t map).
REQ-005 BRAM_DOUT  in  16  controller-BRAM read data; read latency 2 CLK cycles.
REQ-006 MOD_REQ_RD_SEGMENT out 1 / MOD_CYCLE out 32 / MOD_FREQ_DIV out 32 / MOD_REP out 32 / MOD_TRANSITION_MODE out 8 / MOD_TRANSITION_VALUE out 64  shadowed modulation settings.
REQ-007 MOD_UPDATE  out  1  one-cycle pulse; MOD_* outputs newly valid.
REQ-008 STM_REQ_RD_SEGMENT 1, STM_CYCLE 32, STM_FREQ_DIV 32, STM_REP 32, STM_MODE 1, STM_SOUND_SPEED 32, STM_NUM_FOCI 8, STM_TRANSITION_MODE 8, STM_TRANSITION_VALUE 64, STM_UPDATE 1  out  shadowed STM settings plus update pulse.
REQ-009 BUSY  out  1  high whenever the FSM is not in IDLE.

Function
REQ-010 Multi-word fields SHALL assemble little-endian: the lower address supplies bits [15:0], each next address the next 16 bits.
REQ-011 Single-bit/8-bit fields SHALL take BRAM_DOUT[0] or BRAM_DOUT[7:0] of their word (REQ_RD_SEGMENT, TRANSITION_MODE, STM_MODE from 0x59, NUM_FOCI from 0x5D); unused words (0x5A, 0x5E) are read and discarded.
REQ-012 FSM states: PRIME, IDLE, MOD_RD, MOD_DONE, STM_RD, STM_DONE.
REQ-013 PRIME: BRAM_ADDR=0x00 for 2 cycles, then IDLE; entered after reset and after every DONE state.
REQ-014 IDLE: BRAM_ADDR=0x00 each cycle; prev_mod/prev_stm registers sample ADDR_CTL_FLAG bits 0/1 every IDLE cycle.
REQ-015 Trigger: bit0 (MOD_SET) =1 with prev_mod=0 -> MOD_RD; else bit1 (STM_SET) =1 with prev_stm=0 -> STM_RD.
REQ-016 Simultaneous rising MOD_SET and STM_SET: MOD group first; prev_stm left 0 so STM triggers on the next IDLE evaluation.
REQ-017 MOD_RD: with trigger in cycle t, addresses 0x22..0x2D issued at t+1..t+12, one per cycle; data captured into internal shadows at t+3..t+14.
REQ-018 MOD_DONE at t+15: all MOD_* outputs update atomically and MOD_UPDATE=1 for exactly that cycle.
REQ-019 STM_RD: addresses 0x52..0x63 at t+1..t+18; STM_* outputs update atomically with STM_UPDATE=1 at t+21.
REQ-020 Outputs SHALL never show partially-read groups; between updates they hold last values.
REQ-021 Flag edges occurring outside IDLE are not detected; a bit still 1 on return to IDLE does not retrigger (prev retains 1).
REQ-022 BRAM_ADDR is registered; no combinational path from BRAM_DOUT to any output.

Reset
REQ-023 RST SHALL set state PRIME, BRAM_ADDR=0x00, every output 0, shadows and prev_mod/prev_stm 0.
REQ-024 RST mid-read SHALL abort the read without any UPDATE pulse.
REQ-025 A flag bit already 1 at reset release SHALL trigger one read (prev=0).

Configuration
REQ-026 Macro CTL_REG_READER_STM_EN: defined -> STM group logic compiled in per REQ-015..019.
REQ-027 Undefined -> STM_RD/STM_DONE absent, bit1 ignored, all STM_* outputs tied 0, ports retained.

Verification
REQ-028 Reset release with flag word 0x0000, hold 50 cycles -> no UPDATE, BUSY=0 after 2 cycles, BRAM_ADDR=0x00.
REQ-029 Flag 0x0001, words 0x23=0x1234, 0x24=0x0000, 0x25=0x0005, 0x29=0x0001 -> MOD_UPDATE 15 cycles after detect, MOD_CYCLE=0x00001234, MOD_FREQ_DIV=0x00000005, MOD_TRANSITION_MODE=0x01.
REQ-030 Flag 0x0003 (macro on), 0x5D=0x0008 -> MOD_UPDATE first, then STM_UPDATE with STM_NUM_FOCI=8; exactly one pulse each.
REQ-031 Flag held 0x0001 for 200 cycles -> exactly one MOD_UPDATE; 0 then 1 again -> second MOD_UPDATE.
REQ-032 RST asserted at trigger+6 -> no MOD_UPDATE, outputs 0, PRIME re-entered.
REQ-033 Macro off, flag 0x0002 -> no STM_UPDATE, STM_* remain 0.
